// File: rtl/wb_arbiter_if.sv
// Bus bundle between the pipeline/mult-div units and the regfile writeback arbiter.
// The master side drives requests and queries; the slave side is the arbiter.
interface wb_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        md_ready;
  logic [4:0]  query_reg;
  logic        query_hit;
  logic        md_drain_req;
  logic [2:0]  fifo_count;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  modport master (
    output pipe_we, pipe_reg, pipe_data, md_valid, md_reg, md_data, query_reg,
    input  md_ready, query_hit, md_drain_req, fifo_count,
           ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

  modport slave (
    input  pipe_we, pipe_reg, pipe_data, md_valid, md_reg, md_data, query_reg,
    output md_ready, query_hit, md_drain_req, fifo_count,
           ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
endinterface

// File: rtl/wb_arbiter.sv
// Regfile writeback arbiter: pipeline writes take priority, mult/div results
// wait in a 4-entry in-order FIFO and drain into otherwise idle writeback slots.
module wb_arbiter (
  input logic          clock,
  input logic          ctrl_reset,
  wb_arbiter_if.slave  bus
);
  localparam int DEPTH = 4;

  logic [4:0]  r_mem_reg  [DEPTH];
  logic [31:0] r_mem_data [DEPTH];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;
  logic [2:0]  r_starve;
  logic        r_drain;
  logic        r_we;
  logic [4:0]  r_wreg;
  logic [31:0] r_wdata;

  logic             w_ready;
  logic             w_push;
  logic             w_pipe;
  logic             w_pop;
  logic [2:0]       w_count_next;
  logic [2:0]       w_starve_next;
  logic [DEPTH-1:0] w_occupied;
  logic [DEPTH-1:0] w_match;

  assign w_ready = (r_count != 3'd4) && !ctrl_reset;
  assign w_push  = bus.md_valid && w_ready && (bus.md_reg != 5'd0);
  assign w_pipe  = bus.pipe_we && (bus.pipe_reg != 5'd0);
  // The pop decision uses the pre-edge count, so a fresh push is never popped in its own cycle.
  assign w_pop   = !w_pipe && (r_count != 3'd0);

  // Slot gi is live when its distance from the read pointer is below the count.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [1:0] w_off;
      assign w_off          = 2'(gi) - r_rptr;
      assign w_occupied[gi] = {1'b0, w_off} < r_count;
      assign w_match[gi]    = (r_mem_reg[gi] == bus.query_reg);
    end
  endgenerate

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 3'd1;
      2'b01:   w_count_next = r_count - 3'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Saturates at 7 so a long stall keeps the drain request asserted.
  always_comb begin
    w_starve_next = r_starve;
    if (w_pop || (r_count == 3'd0)) begin
      w_starve_next = 3'd0;
    end else if (r_starve != 3'd7) begin
      w_starve_next = r_starve + 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_reg[r_wptr]  <= bus.md_reg;
      r_mem_data[r_wptr] <= bus.md_data;
    end
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      r_wptr   <= 2'd0;
      r_rptr   <= 2'd0;
      r_count  <= 3'd0;
      r_starve <= 3'd0;
      r_drain  <= 1'b0;
      r_we     <= 1'b0;
      r_wreg   <= 5'd0;
      r_wdata  <= 32'd0;
    end else begin
      r_count  <= w_count_next;
      r_starve <= w_starve_next;
      if (w_push) begin
        r_wptr <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + 2'd1;
        r_drain <= 1'b0;
      end else if (w_starve_next == 3'd7) begin
        r_drain <= 1'b1;
      end
      if (w_pipe) begin
        r_we    <= 1'b1;
        r_wreg  <= bus.pipe_reg;
        r_wdata <= bus.pipe_data;
      end else if (w_pop) begin
        r_we    <= 1'b1;
        r_wreg  <= r_mem_reg[r_rptr];
        r_wdata <= r_mem_data[r_rptr];
      end else begin
        r_we <= 1'b0;
      end
    end
  end

  assign bus.md_ready         = w_ready;
  assign bus.query_hit        = (bus.query_reg != 5'd0) && |(w_match & w_occupied);
  assign bus.md_drain_req     = r_drain;
  assign bus.fifo_count       = r_count;
  assign bus.ctrl_writeEnable = r_we;
  assign bus.ctrl_writeReg    = r_wreg;
  assign bus.data_writeReg    = r_wdata;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter: one task per scenario, expected
// values written out by hand from the intended writeback behaviour.
module tb_wb_arbiter;
  logic clock;
  logic ctrl_reset;
  int   checks = 0;
  int   errors = 0;

  wb_arbiter_if bus ();

  wb_arbiter dut (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clock) begin
    if (bus.ctrl_writeEnable === 1'b1)
      $display("write r%0d = %h (fifo_count=%0d)", bus.ctrl_writeReg, bus.data_writeReg, bus.fifo_count);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pipe_we   = 1'b0;
    bus.pipe_reg  = 5'd0;
    bus.pipe_data = 32'd0;
    bus.md_valid  = 1'b0;
    bus.md_reg    = 5'd0;
    bus.md_data   = 32'd0;
    bus.query_reg = 5'd0;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", bus.md_ready); end
    ctrl_reset = 1'b0;
    bus.query_reg = 5'd5;
    #1;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.ctrl_writeEnable); end
    checks++; if (bus.ctrl_writeReg !== 5'd0) begin errors++; $display("FAIL reset_wreg: got %0d expected 0", bus.ctrl_writeReg); end
    checks++; if (bus.data_writeReg !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.data_writeReg); end
    checks++; if (bus.md_drain_req !== 1'b0) begin errors++; $display("FAIL reset_drain: got %b expected 0", bus.md_drain_req); end
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.md_ready); end
    checks++; if (bus.query_hit !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b expected 0", bus.query_hit); end
  endtask

  task automatic test_pipe_only();
    bus.pipe_we = 1'b1; bus.pipe_reg = 5'd5; bus.pipe_data = 32'hDEADBEEF;
    tick();
    bus.pipe_we = 1'b0; bus.pipe_reg = 5'd9; bus.pipe_data = 32'h12345678;
    checks++; if (bus.ctrl_writeEnable !== 1'b1) begin errors++; $display("FAIL pipe_we: got %b expected 1", bus.ctrl_writeEnable); end
    checks++; if (bus.ctrl_writeReg !== 5'd5) begin errors++; $display("FAIL pipe_wreg: got %0d expected 5", bus.ctrl_writeReg); end
    checks++; if (bus.data_writeReg !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_wdata: got %h expected deadbeef", bus.data_writeReg); end
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL pipe_idle_we: got %b expected 0", bus.ctrl_writeEnable); end
    checks++; if (bus.ctrl_writeReg !== 5'd5) begin errors++; $display("FAIL pipe_hold_wreg: got %0d expected 5", bus.ctrl_writeReg); end
    checks++; if (bus.data_writeReg !== 32'hDEADBEEF) begin errors++; $display("FAIL pipe_hold_wdata: got %h expected deadbeef", bus.data_writeReg); end
  endtask

  task automatic test_collision();
    bus.md_valid = 1'b1; bus.md_reg = 5'd3; bus.md_data = 32'h11;
    bus.query_reg = 5'd3;
    tick();
    bus.md_valid = 1'b0;
    bus.pipe_we = 1'b1; bus.pipe_reg = 5'd4; bus.pipe_data = 32'h44;
    #1;
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL coll_count: got %0d expected 1", bus.fifo_count); end
    checks++; if (bus.query_hit !== 1'b1) begin errors++; $display("FAIL coll_hit0: got %b expected 1", bus.query_hit); end
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd4 || bus.data_writeReg !== 32'h44)
        begin errors++; $display("FAIL coll_pipe%0d: got we=%b r%0d=%h expected we=1 r4=00000044", c, bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
      checks++; if (bus.query_hit !== 1'b1) begin errors++; $display("FAIL coll_hit%0d: got %b expected 1", c, bus.query_hit); end
    end
    bus.pipe_we = 1'b0;
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd3 || bus.data_writeReg !== 32'h11)
      begin errors++; $display("FAIL coll_md: got we=%b r%0d=%h expected we=1 r3=00000011", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
    checks++; if (bus.query_hit !== 1'b0) begin errors++; $display("FAIL coll_hit_after: got %b expected 0", bus.query_hit); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL coll_count_after: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_full();
    bus.pipe_we = 1'b1; bus.pipe_reg = 5'd7; bus.pipe_data = 32'h77;
    for (int i = 1; i <= 4; i++) begin
      bus.md_valid = 1'b1; bus.md_reg = 5'(i); bus.md_data = 32'h100 + 32'(i);
      tick();
    end
    bus.md_valid = 1'b0;
    bus.query_reg = 5'd4;
    #1;
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", bus.fifo_count); end
    checks++; if (bus.md_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", bus.md_ready); end
    checks++; if (bus.query_hit !== 1'b1) begin errors++; $display("FAIL full_hit4: got %b expected 1", bus.query_hit); end
    bus.query_reg = 5'd9;
    #1;
    checks++; if (bus.query_hit !== 1'b0) begin errors++; $display("FAIL full_hit9: got %b expected 0", bus.query_hit); end
    bus.pipe_we = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'(i) || bus.data_writeReg !== 32'h100 + 32'(i))
        begin errors++; $display("FAIL full_pop%0d: got we=%b r%0d=%h expected we=1 r%0d=%h", i, bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg, i, 32'h100 + 32'(i)); end
      checks++; if (bus.fifo_count !== 3'(4 - i) || bus.md_ready !== 1'b1)
        begin errors++; $display("FAIL full_count%0d: got count=%0d ready=%b expected count=%0d ready=1", i, bus.fifo_count, bus.md_ready, 4 - i); end
    end
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL full_drained_we: got %b expected 0", bus.ctrl_writeEnable); end
  endtask

  task automatic test_starvation();
    bus.md_valid = 1'b1; bus.md_reg = 5'd10; bus.md_data = 32'hAA;
    bus.pipe_we = 1'b1; bus.pipe_reg = 5'd6; bus.pipe_data = 32'h66;
    tick();
    bus.md_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checks++; if (bus.md_drain_req !== (i >= 7))
        begin errors++; $display("FAIL starve_drain%0d: got %b expected %b", i, bus.md_drain_req, (i >= 7)); end
    end
    bus.pipe_we = 1'b0;
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd10 || bus.data_writeReg !== 32'hAA)
      begin errors++; $display("FAIL starve_pop: got we=%b r%0d=%h expected we=1 r10=000000aa", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
    checks++; if (bus.md_drain_req !== 1'b0) begin errors++; $display("FAIL starve_release: got %b expected 0", bus.md_drain_req); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL starve_count: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_zero_reg();
    bus.md_valid = 1'b1; bus.md_reg = 5'd0; bus.md_data = 32'h77;
    #1;
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", bus.md_ready); end
    tick();
    bus.md_valid = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL zero_md_count: got %0d expected 0", bus.fifo_count); end
    bus.md_valid = 1'b1; bus.md_reg = 5'd12; bus.md_data = 32'h55;
    tick();
    bus.md_valid = 1'b0;
    bus.pipe_we = 1'b1; bus.pipe_reg = 5'd0; bus.pipe_data = 32'h99;
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL zero_push_count: got %0d expected 1", bus.fifo_count); end
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b1 || bus.ctrl_writeReg !== 5'd12 || bus.data_writeReg !== 32'h55)
      begin errors++; $display("FAIL zero_drain: got we=%b r%0d=%h expected we=1 r12=00000055", bus.ctrl_writeEnable, bus.ctrl_writeReg, bus.data_writeReg); end
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL zero_pipe_we: got %b expected 0", bus.ctrl_writeEnable); end
    bus.pipe_we = 1'b0;
  endtask

  task automatic test_reset_mid();
    int hits;
    bus.pipe_we = 1'b1; bus.pipe_reg = 5'd2; bus.pipe_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      bus.md_valid = 1'b1; bus.md_reg = 5'(20 + i); bus.md_data = 32'hC0 + 32'(i);
      tick();
    end
    bus.md_valid = 1'b0;
    bus.query_reg = 5'd21;
    #1;
    checks++; if (bus.fifo_count !== 3'd3 || bus.query_hit !== 1'b1)
      begin errors++; $display("FAIL mid_queued: got count=%0d hit=%b expected count=3 hit=1", bus.fifo_count, bus.query_hit); end
    ctrl_reset = 1'b1;
    bus.md_valid = 1'b1; bus.md_reg = 5'd23; bus.md_data = 32'hEE;
    tick();
    ctrl_reset = 1'b0;
    idle_inputs();
    #1;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL mid_we: got %b expected 0", bus.ctrl_writeEnable); end
    checks++; if (bus.md_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", bus.md_ready); end
    hits = 0;
    for (int r = 0; r < 32; r++) begin
      bus.query_reg = 5'(r);
      #1;
      if (bus.query_hit !== 1'b0) hits++;
    end
    checks++; if (hits !== 0) begin errors++; $display("FAIL mid_hits: got %0d registers hit expected 0", hits); end
    tick();
    checks++; if (bus.ctrl_writeEnable !== 1'b0) begin errors++; $display("FAIL mid_no_write: got %b expected 0", bus.ctrl_writeEnable); end
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_collision();
    test_full();
    test_starvation();
    test_zero_reg();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
